// File: rtl/cpu_pkg.sv
// Shared core definitions: branch command encodings, opcodes and the squash NOP word.
// Imported by the fetch stage and by CPU_Controller.
package cpu_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_JUMP = 2'd1,
        BR_BNE  = 2'd2,
        BR_BEZ  = 2'd3
    } br_cmd_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_NOP   = 6'b000001;
    localparam logic [5:0] OP_JUMP  = 6'b000010;
    localparam logic [5:0] OP_BEZ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [31:0] NOP_WORD = {OP_NOP, 26'd0};

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: imem port, ID-stage branch inputs, IF/ID register outputs.
// slave = the fetch stage, master = its surroundings (imem, decoder, hazard unit).
interface fetch_stage_if #(parameter int ADDR_WIDTH = 32);
    import cpu_pkg::*;

    logic                  Freeze;
    br_cmd_t               BranchCommand;
    logic [31:0]           Val1;
    logic [31:0]           Val2;
    logic [ADDR_WIDTH-1:0] Imem_Addr;
    logic [31:0]           Imem_Data;
    logic [31:0]           Instruction_ID;
    logic [ADDR_WIDTH-1:0] PC_ID;
    logic                  Valid_ID;
    logic                  Br_Taken;

    modport slave (
        input  Freeze, BranchCommand, Val1, Val2, Imem_Data,
        output Imem_Addr, Instruction_ID, PC_ID, Valid_ID, Br_Taken
    );

    modport master (
        output Freeze, BranchCommand, Val1, Val2, Imem_Data,
        input  Imem_Addr, Instruction_ID, PC_ID, Valid_ID, Br_Taken
    );

endinterface

// File: rtl/branch_unit.sv
// ID-stage branch resolution: operand compare, taken decision and target select.
// Purely combinational; a frozen or squashed ID slot never reports taken.
module branch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  br_cmd_t               cmd,
    input  logic [31:0]           val1,
    input  logic [31:0]           val2,
    input  logic [25:0]           instr_low,
    input  logic [ADDR_WIDTH-1:0] pc_id,
    input  logic                  valid_id,
    input  logic                  freeze,
    output logic                  taken,
    output logic [ADDR_WIDTH-1:0] target
);

    logic                  live;
    logic                  equal;
    logic [31:0]           br_off;
    logic [ADDR_WIDTH-1:0] br_target;
    logic [ADDR_WIDTH-1:0] jmp_target;

    assign live       = valid_id & ~freeze;
    assign equal      = (val1 == val2);
    assign br_off     = sext16(instr_low[15:0]) << 2;
    assign br_target  = pc_id + ADDR_WIDTH'(br_off);
    assign jmp_target = {pc_id[ADDR_WIDTH-1:28], instr_low, 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = br_target;
        case (cmd)
            BR_JUMP: begin
                taken  = live;
                target = jmp_target;
            end
            BR_BEZ:  taken = live & equal;
            BR_BNE:  taken = live & ~equal;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// PC register, IF/ID pipeline register and ID-stage redirect; fetch latency 1, taken branch costs one bubble.
// Freeze holds PC and IF/ID; update priority is Rst > Freeze > redirect > sequential fetch.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic          Clk,
    input  logic          Rst,
    fetch_stage_if.slave  fif
);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] pc_id;
    logic [31:0]           instr_id;
    logic                  valid_id;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] target;

    assign pc_plus4 = pc + ADDR_WIDTH'(4);

    branch_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_branch (
        .cmd       (fif.BranchCommand),
        .val1      (fif.Val1),
        .val2      (fif.Val2),
        .instr_low (instr_id[25:0]),
        .pc_id     (pc_id),
        .valid_id  (valid_id),
        .freeze    (fif.Freeze),
        .taken     (taken),
        .target    (target)
    );

    // A redirect overwrites the word fetched this cycle with a NOP so it never executes.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc       <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
            instr_id <= NOP_WORD;
            pc_id    <= '0;
            valid_id <= 1'b0;
        end else if (fif.Freeze) begin
            pc       <= pc;
            instr_id <= instr_id;
            pc_id    <= pc_id;
            valid_id <= valid_id;
        end else if (taken) begin
            pc       <= target;
            instr_id <= NOP_WORD;
            pc_id    <= '0;
            valid_id <= 1'b0;
        end else begin
            pc       <= pc_plus4;
            instr_id <= fif.Imem_Data;
            pc_id    <= pc_plus4;
            valid_id <= 1'b1;
        end
    end

    assign fif.Imem_Addr      = pc;
    assign fif.Instruction_ID = instr_id;
    assign fif.PC_ID          = pc_id;
    assign fif.Valid_ID       = valid_id;
    assign fif.Br_Taken       = taken;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle reference model plus hand-computed literal checks.
// A second instance with a high reset PC exercises the jump-target region bits.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_hi = 1'b1;
    int   prog_sel = 0;
    int   errors = 0;
    int   checks = 0;
    bit   model_on = 1'b0;

    always #5 clk = ~clk;

    fetch_stage_if #(.ADDR_WIDTH(32)) dif ();
    fetch_stage_if #(.ADDR_WIDTH(32)) hif ();

    fetch_stage #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .Clk (clk),
        .Rst (rst),
        .fif (dif.slave)
    );

    fetch_stage #(.ADDR_WIDTH(32), .RESET_PC(32'h1000_0008)) dut_hi (
        .Clk (clk),
        .Rst (rst_hi),
        .fif (hif.slave)
    );

    // Program images; unlisted addresses return a tag word carrying the low address bits.
    function automatic logic [31:0] imem(input logic [31:0] a, input int sel);
        logic [31:0] w;
        w = {16'hC0DE, a[15:0]};
        case (sel)
            1: if (a == 32'd4) w = {6'b000100, 5'd1, 5'd2, 16'd3};
            2: if (a == 32'h1000_000C) w = {6'b000010, 26'h40};
            3: begin
                if (a == 32'd4) w = {6'b000101, 5'd1, 5'd2, 16'd4};
                if (a == 32'd8) w = {6'b000100, 5'd3, 5'd3, 16'd1};
            end
            4: if (a == 32'd4) w = {6'b000100, 5'd1, 5'd2, 16'hFFFD};
            default: ;
        endcase
        return w;
    endfunction

    always @* dif.Imem_Data = imem(dif.Imem_Addr, prog_sel);
    always @* hif.Imem_Data = imem(hif.Imem_Addr, 2);

    // Reference model of the main instance
    logic [31:0] m_pc, m_ins, m_pcid;
    logic        m_vld;

    function automatic logic model_taken();
        logic t;
        t = m_vld && !dif.Freeze;
        if (dif.BranchCommand == BR_JUMP) return t;
        if (dif.BranchCommand == BR_BEZ)  return t && (dif.Val1 == dif.Val2);
        if (dif.BranchCommand == BR_BNE)  return t && (dif.Val1 != dif.Val2);
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_target();
        int off;
        if (dif.BranchCommand == BR_JUMP)
            return (m_pcid & 32'hF000_0000) | ((m_ins & 32'h03FF_FFFF) * 4);
        off = int'($signed(m_ins[15:0]));
        return m_pcid + 32'(off * 4);
    endfunction

    always @(posedge clk) begin
        logic tk;
        logic [31:0] tgt;
        tk  = model_taken();
        tgt = model_target();
        if (rst) begin
            m_pc <= 32'd0; m_ins <= 32'h0400_0000; m_pcid <= 32'd0; m_vld <= 1'b0;
            model_on <= 1'b1;
        end else if (dif.Freeze) begin
            m_pc <= m_pc;
        end else if (tk) begin
            m_pc <= tgt; m_ins <= 32'h0400_0000; m_pcid <= 32'd0; m_vld <= 1'b0;
        end else begin
            m_pc <= m_pc + 32'd4; m_ins <= imem(m_pc, prog_sel);
            m_pcid <= m_pc + 32'd4; m_vld <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            chk("model imem_addr", dif.Imem_Addr, m_pc);
            chk("model instruction_id", dif.Instruction_ID, m_ins);
            chk("model pc_id", dif.PC_ID, m_pcid);
            chk("model valid_id", 32'(dif.Valid_ID), 32'(m_vld));
            chk("model br_taken", 32'(dif.Br_Taken), 32'(model_taken()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic restart(input int sel);
        rst = 1'b1; prog_sel = sel;
        dif.BranchCommand = BR_NONE;
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        dif.Freeze = 1'b0; dif.BranchCommand = BR_NONE; dif.Val1 = '0; dif.Val2 = '0;
        hif.Freeze = 1'b0; hif.BranchCommand = BR_NONE; hif.Val1 = '0; hif.Val2 = '0;

        // reset state and free run
        cyc(); cyc(); #1;
        chk("reset imem_addr", dif.Imem_Addr, 32'd0);
        chk("reset valid", 32'(dif.Valid_ID), 32'd0);
        chk("reset instr nop", dif.Instruction_ID, 32'h0400_0000);
        chk("reset pc_id", dif.PC_ID, 32'd0);
        rst = 1'b0;
        cyc(); #1;
        chk("first instr", dif.Instruction_ID, 32'hC0DE_0000);
        chk("first pc_id", dif.PC_ID, 32'd4);
        chk("first valid", 32'(dif.Valid_ID), 32'd1);
        chk("first imem_addr", dif.Imem_Addr, 32'd4);
        cyc(); #1;
        chk("run imem_addr 8", dif.Imem_Addr, 32'd8);

        // freeze three cycles at PC 8
        dif.Freeze = 1'b1;
        cyc(); cyc(); cyc(); #1;
        chk("freeze imem_addr", dif.Imem_Addr, 32'd8);
        chk("freeze pc_id", dif.PC_ID, 32'd8);
        chk("freeze instr", dif.Instruction_ID, 32'hC0DE_0004);
        dif.Freeze = 1'b0;
        cyc(); #1;
        chk("unfreeze imem_addr", dif.Imem_Addr, 32'd12);
        chk("unfreeze instr", dif.Instruction_ID, 32'hC0DE_0008);

        // BEZ taken at 4, imm 3 -> 20; squashed slot cannot fire
        restart(1);
        dif.BranchCommand = BR_BEZ; dif.Val1 = 32'd5; dif.Val2 = 32'd5; #1;
        chk("bez taken", 32'(dif.Br_Taken), 32'd1);
        cyc(); #1;
        chk("bez target", dif.Imem_Addr, 32'd20);
        chk("bez slot nop", dif.Instruction_ID, 32'h0400_0000);
        chk("bez slot invalid", 32'(dif.Valid_ID), 32'd0);
        chk("squashed no fire", 32'(dif.Br_Taken), 32'd0);
        dif.BranchCommand = BR_NONE;
        cyc(); #1;
        chk("bez target instr", dif.Instruction_ID, 32'hC0DE_0014);
        chk("bez target pc_id", dif.PC_ID, 32'd24);

        // BEZ not taken
        restart(1);
        dif.BranchCommand = BR_BEZ; dif.Val1 = 32'd5; dif.Val2 = 32'd6; #1;
        chk("bez not taken", 32'(dif.Br_Taken), 32'd0);
        cyc();
        dif.BranchCommand = BR_NONE; #1;
        chk("bez nt imem_addr", dif.Imem_Addr, 32'd12);
        chk("bez nt instr", dif.Instruction_ID, 32'hC0DE_0008);

        // BNE taken then BEZ in the squashed slot
        restart(3);
        dif.BranchCommand = BR_BNE; dif.Val1 = 32'd1; dif.Val2 = 32'd2; #1;
        chk("bne taken", 32'(dif.Br_Taken), 32'd1);
        cyc();
        dif.BranchCommand = BR_BEZ; dif.Val1 = 32'd7; dif.Val2 = 32'd7; #1;
        chk("bez after bne", 32'(dif.Br_Taken), 32'd0);
        chk("bne target", dif.Imem_Addr, 32'd24);
        dif.BranchCommand = BR_NONE;
        cyc(); #1;
        chk("bne target instr", dif.Instruction_ID, 32'hC0DE_0018);
        chk("bne target pc_id", dif.PC_ID, 32'd28);

        // backward branch to FFFF_FFFC then wrap to 0
        restart(4);
        dif.BranchCommand = BR_BEZ; dif.Val1 = 32'd0; dif.Val2 = 32'd0; #1;
        chk("neg branch taken", 32'(dif.Br_Taken), 32'd1);
        cyc();
        dif.BranchCommand = BR_NONE; #1;
        chk("neg target", dif.Imem_Addr, 32'hFFFF_FFFC);
        cyc(); #1;
        chk("wrap imem_addr", dif.Imem_Addr, 32'd0);
        chk("wrap pc_id", dif.PC_ID, 32'd0);
        chk("wrap instr", dif.Instruction_ID, 32'hC0DE_FFFC);

        // Rst in the same cycle as a taken branch
        restart(1);
        dif.BranchCommand = BR_BEZ; dif.Val1 = 32'd3; dif.Val2 = 32'd3;
        rst = 1'b1; #1;
        chk("rst+br taken comb", 32'(dif.Br_Taken), 32'd1);
        cyc(); #1;
        chk("rst wins pc", dif.Imem_Addr, 32'd0);
        chk("rst wins valid", 32'(dif.Valid_ID), 32'd0);
        chk("rst wins instr", dif.Instruction_ID, 32'h0400_0000);
        rst = 1'b0; dif.BranchCommand = BR_NONE;

        // JUMP from 1000_000C, held under freeze first
        rst_hi = 1'b0;
        cyc(); cyc();
        hif.BranchCommand = BR_JUMP; hif.Freeze = 1'b1; #1;
        chk("jump pc_id", hif.PC_ID, 32'h1000_0010);
        chk("jump frozen no taken", 32'(hif.Br_Taken), 32'd0);
        cyc(); #1;
        chk("jump frozen pc", hif.Imem_Addr, 32'h1000_0010);
        chk("jump frozen still", 32'(hif.Br_Taken), 32'd0);
        hif.Freeze = 1'b0; #1;
        chk("jump taken", 32'(hif.Br_Taken), 32'd1);
        cyc();
        hif.BranchCommand = BR_NONE; #1;
        chk("jump target", hif.Imem_Addr, 32'h1000_0100);
        chk("jump slot invalid", 32'(hif.Valid_ID), 32'd0);
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core. It holds the PC and drives the instruction-memory address. It latches the fetched word and PC+4 into the IF/ID register. It also resolves branches and jumps in ID, using the decoder's BranchCommand and the register-file operands. The IF/ID instruction register feeds Opcode/Function to CPU_Controller. A taken branch redirects the PC and squashes the wrong-path fetch, costing one bubble.

## Interface
- ADDR_WIDTH, 32, PC / address width.
- RESET_PC, 32'h0000_0000, PC value after reset; must be word aligned.
- Clk  in  1  rising-edge clock.
- Rst  in  1  reset, synchronous, active-high.
- Freeze  in  1  stall from the hazard unit; holds PC and IF/ID.
- BranchCommand  in  2  decoder branch command for the instruction in ID: 0 none, 1 JUMP, 2 BNE, 3 BEZ (branch if equal).
- Val1  in  32  rs operand of the ID instruction.
- Val2  in  32  rt operand of the ID instruction.
- Imem_Addr  out  ADDR_WIDTH  instruction-memory address; equals PC.
- Imem_Data  in  32  instruction word; combinational read of Imem_Addr.
- Instruction_ID  out  32  IF/ID instruction register.
- PC_ID  out  ADDR_WIDTH  IF/ID PC+4 register.
- Valid_ID  out  1  IF/ID holds a real fetched instruction.
- Br_Taken  out  1  redirect this cycle; used by the hazard unit and for debug.

## Operation
- Taken condition, combinational, with t = Valid_ID & ~Freeze:
  - JUMP: Br_Taken = t.
  - BEZ: Br_Taken = t & (Val1 == Val2).
  - BNE: Br_Taken = t & (Val1 != Val2).
  - BranchCommand 0: Br_Taken = 0.
- Targets, from the IF/ID register only:
  - Branch: PC_ID + sign_extend(Instruction_ID[15:0]) << 2.
  - Jump: {PC_ID[31:28], Instruction_ID[25:0], 2'b00}.
- Register update priority per rising edge: Rst > Freeze > Br_Taken > normal.
  - Rst: PC = RESET_PC, Instruction_ID = NOP_WORD (32'h0400_0000, opcode 000001), PC_ID = 0, Valid_ID = 0.
  - Freeze: PC, Instruction_ID, PC_ID and Valid_ID all hold. A branch in ID is not taken while frozen; it is re-evaluated on the first unfrozen cycle.
  - Br_Taken: PC = target; Instruction_ID = NOP_WORD; PC_ID = 0; Valid_ID = 0. This squashes the wrong-path word.
  - Normal: PC = PC + 4; Instruction_ID = Imem_Data; PC_ID = PC + 4; Valid_ID = 1.
- Arithmetic is modulo 2^ADDR_WIDTH: PC 32'hFFFF_FFFC + 4 wraps to 0. PC[1:0] is always 0.
- A squashed slot (Valid_ID = 0) can never produce Br_Taken, whatever its bits.
- Rst asserted mid-branch or mid-freeze wins unconditionally. There is no partial state.

## Timing
- Imem_Addr = PC in the same cycle. The word appears on Instruction_ID one edge later: fetch latency 1.
- Branch resolves in ID. Br_Taken is combinational in the cycle the branch sits in ID. The target instruction reaches ID two edges after the branch entered ID, leaving exactly one NOP bubble.
- Back-to-back branches: the second is the squashed slot and is never executed.
- First valid instruction after Rst deasserts: Imem_Data at RESET_PC is latched at the first edge with Rst = 0. Valid_ID = 1 after that edge.

## Structure
- Shared package cpu_pkg: BranchCommand encodings (BR_NONE, BR_JUMP, BR_BNE, BR_BEZ), NOP_WORD, opcode constants shared with CPU_Controller.
- One combinational sub-module, branch_unit: compare, taken logic and target mux.
- The top level holds the PC register, the IF/ID registers and the update priority.

## Test plan
- Reset then free run with RESET_PC 0: Imem_Addr steps 0, 4, 8, … After the first edge, Instruction_ID = mem[0], PC_ID = 4, Valid_ID = 1.
- Freeze high for 3 cycles with PC = 8: Imem_Addr stays 8 and IF/ID stays unchanged. Fetch resumes at 12 after Freeze drops.
- BEZ at addr 4 with imm 3 and Val1 = Val2 = 5: Br_Taken = 1, next PC = 8 + 12 = 20, the slot is NOP_WORD with Valid_ID = 0. Repeat with Val2 = 6: no redirect.
- JUMP with Instruction_ID[25:0] = 26'h40 and PC_ID = 32'h1000_0010: next PC = 32'h1000_0100. Branch held in ID under Freeze: Br_Taken = 0 until Freeze drops.
- BNE immediately followed by BEZ, first taken: the BEZ slot is squashed and Br_Taken does not fire for it.
- PC at 32'hFFFF_FFFC wraps to 0. Rst asserted in the same cycle as Br_Taken: PC = RESET_PC and Valid_ID = 0.
